// File: rtl/stim_seq_gen.sv
// Stimulus sequencer for the lut_ff_mux golden/post-route pair.
// It runs a DUT reset phase, then four directed vectors, then N_RANDOM vectors
// from a Galois LFSR. Each vector is held for SETTLE cycles and then marked by
// a one-cycle cmp_valid strobe that the downstream checker consumes.
module stim_seq_gen #(
    parameter int          N_RANDOM   = 100,
    parameter int          SETTLE     = 1,
    parameter int          RST_CYCLES = 2,
    parameter int          DRAIN      = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    output logic [3:0] stim_in,
    output logic       stim_mux_sel,
    output logic       dut_rst,
    output logic       cmp_valid,
    output logic [7:0] vec_idx,
    output logic       busy,
    output logic       done
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [7:0]  LAST_IDX = 8'(N_RANDOM + 3);
    localparam logic [3:0]  SETTLE_P = 4'(SETTLE);
    localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [7:0]  DRN_LAST = 8'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUT_RST,
        S_DIRECTED,
        S_RANDOM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  in_q, in_d;
    logic        sel_q, sel_d;

    // One right-shift step of the Galois LFSR, taps 16'hB400.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Directed vector table, packed as {sel, in[3:0]}.
    function automatic logic [4:0] dir_vec(input logic [1:0] i);
        case (i)
            2'd0:    return 5'b0_0100;
            2'd1:    return 5'b1_0100;
            2'd2:    return 5'b0_0001;
            default: return 5'b1_0001;
        endcase
    endfunction

    // State and datapath registers; rst returns everything to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            lfsr_q  <= SEED;
            in_q    <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            in_q    <= in_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        lfsr_d       = lfsr_q;
        in_d         = in_q;
        sel_d        = sel_q;
        cmp_valid    = 1'b0;
        dut_rst      = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                done = (state_q == S_DONE);
                if (start) begin
                    state_d = S_DUT_RST;
                    cnt_d   = '0;
                    idx_d   = '0;
                    lfsr_d  = SEED;
                    in_d    = '0;
                    sel_d   = 1'b0;
                end
            end

            // hold is deliberately ignored while the DUT is in reset.
            S_DUT_RST: begin
                dut_rst = 1'b1;
                if (cnt_q == RST_LAST) begin
                    state_d          = S_DIRECTED;
                    phase_d          = '0;
                    idx_d            = '0;
                    {sel_d, in_d}    = dir_vec(2'd0);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DIRECTED, S_RANDOM: begin
                // A held compare stays pending because phase stays at SETTLE.
                cmp_valid = !rst && !hold && (phase_q == SETTLE_P);
                if (!hold) begin
                    if (phase_q != SETTLE_P) begin
                        phase_d = phase_q + 4'd1;
                    end else begin
                        phase_d = '0;
                        if (state_q == S_DIRECTED) begin
                            if (idx_q[1:0] == 2'd3) begin
                                // First random vector uses the seed itself.
                                state_d = S_RANDOM;
                                idx_d   = 8'd4;
                                in_d    = lfsr_q[3:0];
                                sel_d   = lfsr_q[4];
                            end else begin
                                idx_d         = idx_q + 8'd1;
                                {sel_d, in_d} = dir_vec(idx_q[1:0] + 2'd1);
                            end
                        end else if (idx_q == LAST_IDX) begin
                            cnt_d   = '0;
                            state_d = (DRAIN == 0) ? S_DONE : S_DRAIN;
                        end else begin
                            lfsr_d = lfsr_step(lfsr_q);
                            idx_d  = idx_q + 8'd1;
                            in_d   = lfsr_d[3:0];
                            sel_d  = lfsr_d[4];
                        end
                    end
                end
            end

            S_DRAIN: begin
                if (!hold) begin
                    if (cnt_q == DRN_LAST) state_d = S_DONE;
                    else                   cnt_d   = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stim_in      = in_q;
    assign stim_mux_sel = sel_q;
    assign vec_idx      = idx_q;

endmodule

// File: tb/tb_stim_seq_gen.sv
// Randomized self-checking bench for stim_seq_gen. The reference model views a
// run as a count of "work units" (unheld cycles after the DUT reset phase):
// vector k occupies units k*(SETTLE+1) .. k*(SETTLE+1)+SETTLE, compares on the
// last of them, and DRAIN further units precede done.
module tb_stim_seq_gen;

    localparam int N_RANDOM   = 100;
    localparam int SETTLE     = 1;
    localparam int RST_CYCLES = 2;
    localparam int DRAIN      = 5;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int NV = N_RANDOM + 4;
    localparam int PER = SETTLE + 1;
    localparam int W  = NV * PER + DRAIN;

    logic       clk = 1'b0;
    logic       rst, start, hold;
    logic [3:0] stim_in;
    logic       stim_mux_sel, dut_rst, cmp_valid, busy, done;
    logic [7:0] vec_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] exp_vec [NV];   // {sel, in}

    stim_seq_gen #(
        .N_RANDOM(N_RANDOM), .SETTLE(SETTLE), .RST_CYCLES(RST_CYCLES),
        .DRAIN(DRAIN), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .stim_in(stim_in), .stim_mux_sel(stim_mux_sel), .dut_rst(dut_rst),
        .cmp_valid(cmp_valid), .vec_idx(vec_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, {28'd0, dut_rst, busy, done, cmp_valid}, 32'd0);
        chk({tag, "_vec"}, {19'd0, stim_mux_sel, stim_in, vec_idx}, 32'd0);
    endtask

    // Expected vector list straight from the directed table and LFSR rule.
    task automatic build_model();
        logic [15:0] l;
        exp_vec[0] = 5'b0_0100;
        exp_vec[1] = 5'b1_0100;
        exp_vec[2] = 5'b0_0001;
        exp_vec[3] = 5'b1_0001;
        l = SEED;
        for (int i = 0; i < N_RANDOM; i++) begin
            exp_vec[4 + i] = {l[4], l[3:0]};
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    // mode 0: no hold; 1: hold 3 cycles on the compare of vector hold_k;
    // 2: random hold and stray start pulses. abort_u>0 stops the run on
    // that work unit (caller then applies rst).
    task automatic run_seq(input int mode, input int hold_k, input int abort_u, input int exp_done_r);
        int u, r, held, ncmp, hk, k;
        logic finishing, e_cmp;
        logic [4:0] ev;
        u = 0; r = 0; held = 0; ncmp = 0; hk = 0;
        @(negedge clk);
        start = 1'b1;
        hold  = 1'b0;
        for (int it = 0; it < 4000; it++) begin
            @(negedge clk);
            r++;
            finishing = (r > RST_CYCLES) && (u == W);
            start = (mode == 2) && !finishing && ($urandom_range(0, 9) == 0);
            if (mode == 2)
                hold = ($urandom_range(0, 3) == 0);
            else if (mode == 1)
                hold = (r > RST_CYCLES) && (u == hold_k * PER + SETTLE) && (hk < 3);
            else
                hold = 1'b0;
            if (hold && mode == 1) hk++;
            #1;
            if (cmp_valid) ncmp++;
            if (r <= RST_CYCLES) begin
                chk("rst_phase_ctl", {dut_rst, busy, done, cmp_valid}, 4'b1100);
                chk("rst_phase_vec", {stim_mux_sel, stim_in, vec_idx}, 13'd0);
            end else if (u < W) begin
                k  = (u < NV * PER) ? u / PER : NV - 1;
                ev = exp_vec[k];
                e_cmp = !hold && (u < NV * PER) && (u % PER == SETTLE);
                chk("ctl", {dut_rst, busy, done}, 3'b010);
                chk("cmp_valid", {31'd0, cmp_valid}, {31'd0, e_cmp});
                chk("vec", {stim_mux_sel, stim_in, vec_idx}, {ev, 8'(k)});
            end else begin
                chk("done_ctl", {dut_rst, busy, done, cmp_valid}, 4'b0010);
                chk("done_vec", {stim_mux_sel, stim_in, vec_idx}, {exp_vec[NV-1], 8'(NV-1)});
                chk("n_cmp", ncmp, NV);
                chk("done_cycle", r, RST_CYCLES + 1 + W + held);
                if (exp_done_r > 0) chk("done_cycle_abs", r, exp_done_r);
                break;
            end
            if (abort_u > 0 && r > RST_CYCLES && u == abort_u) begin
                chk("abort_idx", {24'd0, vec_idx}, abort_u / PER);
                break;
            end
            if (r > RST_CYCLES) begin
                if (hold) held++;
                else      u++;
            end
            if (it == 3999) chk("timeout", 0, 1);
        end
        start = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        build_model();
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check_reset_vals("reset");

        // hold in IDLE has no effect
        @(negedge clk); hold = 1'b1;
        @(negedge clk); #1 check_reset_vals("idle_hold");
        hold = 1'b0;

        // plain run: done at T+216
        run_seq(0, 0, 0, RST_CYCLES + 1 + W);

        // hold in DONE has no effect
        @(negedge clk); hold = 1'b1;
        @(negedge clk); #1;
        chk("done_hold", {28'd0, busy, done, cmp_valid, dut_rst}, 32'b0100);
        hold = 1'b0;

        // 3-cycle hold on the compare of vector 10: end shifts by 3
        run_seq(1, 10, 0, RST_CYCLES + 1 + W + 3);

        // randomized hold / stray start
        for (int i = 0; i < 3; i++) run_seq(2, 0, 0, 0);

        // rst while comparing vec_idx 50, then replay from idx 0
        run_seq(0, 0, 50 * PER + SETTLE, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check_reset_vals("mid_reset");
        run_seq(0, 0, 0, RST_CYCLES + 1 + W);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
